// File: rtl/clk_gating_ctrl.sv
// clk_gating_ctrl: per-channel clock gating controller.
// Each channel runs an OFF/WAKE/ON/IDLE FSM. A registered gate enable feeds a
// low-transparent latch, and the latch output is ANDed with CLK. The enable can
// only change while CLK is low, so every gated high pulse is a full CLK high
// phase. ACK marks a channel whose clock is running and stable. ALL_GATED
// reports that every channel is OFF.
module clk_gating_ctrl #(
  parameter int NUM_CH   = 4,
  parameter int WAKE_CYC = 2,
  parameter int IDLE_CYC = 16,
  parameter int CNT_W    = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NUM_CH-1:0] REQ,
  input  logic [NUM_CH-1:0] CH_EN,
  input  logic              FORCE_ON,
  output logic [NUM_CH-1:0] GATED_CLK,
  output logic [NUM_CH-1:0] ACK,
  output logic              ALL_GATED,
  // Debug view of the channel FSMs: channel i occupies bits [2*i+1:2*i].
  output logic [2*NUM_CH-1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_WAKE = 2'd1,
    S_ON   = 2'd2,
    S_IDLE = 2'd3
  } ch_state_e;

  localparam int MAX_CYC = (WAKE_CYC > IDLE_CYC) ? WAKE_CYC : IDLE_CYC;
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYC - 1);

  // Reject parameter sets that the counters or the channel vector cannot hold.
  generate
    if (NUM_CH < 1 || NUM_CH > 32 || WAKE_CYC < 1 || IDLE_CYC < 1 || CNT_W < 1) begin : g_bad_param
      $error("clk_gating_ctrl: parameter out of range");
    end
    if (CNT_W < 32 && (64'd1 << CNT_W) <= 64'(MAX_CYC)) begin : g_bad_cnt
      $error("clk_gating_ctrl: CNT_W too small for WAKE_CYC/IDLE_CYC");
    end
  endgenerate

  logic [NUM_CH-1:0] gen;
  logic [NUM_CH-1:0] off_next;
  logic [NUM_CH-1:0] en_lat;
  logic              all_gated_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gen_q, ack_q;
    logic             act;

    assign act = REQ[i] | FORCE_ON;

    // State, counter and the registered gate enable / ACK of this channel.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        state_q <= S_OFF;
        cnt_q   <= '0;
        gen_q   <= 1'b0;
        ack_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        gen_q   <= (state_d != S_OFF);
        ack_q   <= (state_d == S_ON) || (state_d == S_IDLE);
      end
    end

    // Next-state and counter logic. Losing the channel permit wins over everything.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!CH_EN[i]) begin
        state_d = S_OFF;
        cnt_d   = '0;
      end else begin
        case (state_q)
          S_OFF: begin
            if (act) begin
              state_d = S_WAKE;
              cnt_d   = '0;
            end
          end
          S_WAKE: begin
            // The request is not looked at until the clock is stable.
            if (cnt_q == WAKE_LAST) begin
              state_d = S_ON;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          S_ON: begin
            if (!act) begin
              state_d = S_IDLE;
              cnt_d   = IDLE_LOAD;
            end
          end
          S_IDLE: begin
            if (act) begin
              state_d = S_ON;
            end else if (cnt_q == '0) begin
              state_d = S_OFF;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
          default: begin
            state_d = S_OFF;
            cnt_d   = '0;
          end
        endcase
      end
    end

    assign gen[i]              = gen_q;
    assign ACK[i]              = ack_q;
    assign off_next[i]         = (state_d == S_OFF);
    assign state_dbg[2*i +: 2] = state_q;
  end

  // Glitch-free gate: the enable passes only while CLK is low and is held through the high phase.
  always_latch begin
    if (RST) begin
      en_lat = '0;
    end else if (!CLK) begin
      en_lat = gen;
    end
  end

  assign GATED_CLK = en_lat & {NUM_CH{CLK}};

  // ALL_GATED reflects the channel states that take effect at this edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      all_gated_q <= 1'b1;
    end else begin
      all_gated_q <= &off_next;
    end
  end

  assign ALL_GATED = all_gated_q;

endmodule

// File: tb/tb_clk_gating_ctrl.sv
// Directed bench for clk_gating_ctrl with default parameters.
// Expected output words {ALL_GATED, ACK[3:0], GATED_CLK[3:0]} are queued as
// stimulus is applied and popped one per edge, sampled 1ns after the edge.
// "Edge n" is the n-th CLK rising edge after the first reset release.
module tb_clk_gating_ctrl;
  localparam int NUM_CH = 4;
  localparam int W      = 9;

  logic              CLK;
  logic              RST;
  logic [NUM_CH-1:0] REQ;
  logic [NUM_CH-1:0] CH_EN;
  logic              FORCE_ON;
  logic [NUM_CH-1:0] GATED_CLK;
  logic [NUM_CH-1:0] ACK;
  logic              ALL_GATED;
  logic [2*NUM_CH-1:0] state_dbg;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  clk_gating_ctrl #(
    .NUM_CH  (4),
    .WAKE_CYC(2),
    .IDLE_CYC(16),
    .CNT_W   (8)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .REQ      (REQ),
    .CH_EN    (CH_EN),
    .FORCE_ON (FORCE_ON),
    .GATED_CLK(GATED_CLK),
    .ACK      (ACK),
    .ALL_GATED(ALL_GATED),
    .state_dbg(state_dbg)
  );

  // Clock and watchdog
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] outs();
    return {ALL_GATED, ACK, GATED_CLK};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic push_n(input int n, input logic [W-1:0] v);
    repeat (n) exp_q.push_back(v);
  endtask

  // One edge: sample after it and compare against the head of the queue.
  task automatic step();
    logic [W-1:0] e;
    @(posedge CLK);
    #1;
    cyc++;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_underflow cyc=%0d observed=empty expected=entry", cyc);
    end else begin
      e = exp_q.pop_front();
      check("outs", outs(), e);
    end
  endtask

  task automatic run_n(input int n);
    repeat (n) step();
  endtask

  // Directed sequence
  initial begin
    RST      = 1'b1;
    REQ      = '0;
    CH_EN    = 4'hF;
    FORCE_ON = 1'b0;

    @(posedge CLK);
    #1;
    check("reset_outs", outs(), 9'b1_0000_0000);
    total++;
    assert (state_dbg === 8'h00) else begin
      bad++;
      $error("FAIL reset_state observed=%h expected=%h", state_dbg, 8'h00);
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    cyc = 0;

    // Edges 1..9: everything gated.
    push_n(9, 9'b1_0000_0000);
    run_n(9);

    // Wake channel 0: REQ sampled at edge 10.
    REQ = 4'b0001;
    push_n(1, 9'b0_0000_0000);
    push_n(1, 9'b0_0000_0001);
    push_n(1, 9'b0_0001_0001);
    run_n(3);

    // Wake channels 1 and 2 together at edge 13.
    REQ = 4'b0111;
    push_n(1, 9'b0_0001_0001);
    push_n(1, 9'b0_0001_0111);
    push_n(5, 9'b0_0111_0111);
    run_n(7);

    // Drop REQ[1] at edge 20: 16 more pulses, last at edge 36, ACK low after 36.
    REQ = 4'b0101;
    push_n(16, 9'b0_0111_0111);
    push_n(1,  9'b0_0101_0111);
    push_n(3,  9'b0_0101_0101);
    run_n(20);

    // Drop REQ[2] at edge 40, re-raise at edge 48: clock and ACK never drop.
    REQ = 4'b0001;
    push_n(8, 9'b0_0101_0101);
    run_n(8);
    REQ = 4'b0101;
    push_n(8, 9'b0_0101_0101);
    run_n(8);

    // Bring channel 3 to ON, then into IDLE at edge 60.
    REQ = 4'b1101;
    push_n(1, 9'b0_0101_0101);
    push_n(1, 9'b0_0101_1101);
    push_n(2, 9'b0_1101_1101);
    run_n(4);
    REQ = 4'b0101;
    push_n(7, 9'b0_1101_1101);
    run_n(7);

    // Idle counter of channel 3 is 9: clearing CH_EN[3] turns it OFF at edge 67.
    // The pulse at edge 67 was already committed; no pulse follows.
    CH_EN = 4'b0111;
    push_n(1, 9'b0_0101_1101);
    push_n(2, 9'b0_0101_0101);
    run_n(3);

    // Disable everything at edge 70.
    CH_EN = 4'b0000;
    push_n(1, 9'b1_0000_0101);
    push_n(2, 9'b1_0000_0000);
    run_n(3);

    // FORCE_ON with only channels 0 and 2 permitted, at edge 73.
    REQ      = 4'b0000;
    FORCE_ON = 1'b1;
    CH_EN    = 4'b0101;
    push_n(1, 9'b0_0000_0000);
    push_n(1, 9'b0_0000_0101);
    push_n(3, 9'b0_0101_0101);
    run_n(5);

    // Force everything off again.
    FORCE_ON = 1'b0;
    CH_EN    = 4'b0000;
    push_n(1, 9'b1_0000_0101);
    push_n(1, 9'b1_0000_0000);
    run_n(2);

    // Start a channel-0 wake at edge 80, then reset in the middle of it.
    CH_EN = 4'hF;
    REQ   = 4'b0001;
    push_n(1, 9'b0_0000_0000);
    push_n(1, 9'b0_0000_0001);
    run_n(2);
    #2;
    RST = 1'b1;
    #1;
    check("rst_async", outs(), 9'b1_0000_0000);
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    check("rst_hold", outs(), 9'b1_0000_0000);
    RST = 1'b0;

    // The held request wakes channel 0 again with the normal latency.
    push_n(1, 9'b0_0000_0000);
    push_n(1, 9'b0_0000_0001);
    push_n(1, 9'b0_0001_0001);
    run_n(3);

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_gating_ctrl.md
CLK_GATING_CTRL -- requirements
Module: clk_gating_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independently gated clock channels, range 1..32.
REQ-002 SHALL have parameter WAKE_CYC, default 2: cycles from wake-up to ACK, minimum 1.
REQ-003 SHALL have parameter IDLE_CYC, default 16: idle cycles with no request before a channel re-gates, minimum 1.
REQ-004 SHALL have parameter CNT_W, default 8: counter width; elaboration fails unless 2^CNT_W > max(WAKE_CYC, IDLE_CYC).
REQ-005 SHALL have port CLK, input, 1 bit: the single free-running source clock; all state changes on its rising edge.
REQ-006 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port REQ, input, NUM_CH bits: per-channel clock request, synchronous to CLK.
REQ-008 SHALL have port CH_EN, input, NUM_CH bits: per-channel permit; 0 forces the channel off.
REQ-009 SHALL have port FORCE_ON, input, 1 bit: global override that acts as a request on every permitted channel.
REQ-010 SHALL have port GATED_CLK, output, NUM_CH bits: per-channel gated copy of CLK.
REQ-011 SHALL have port ACK, output, NUM_CH bits, registered: the channel clock is running and stable.
REQ-012 SHALL have port ALL_GATED, output, 1 bit, registered: every channel is in OFF.

Function
REQ-013 SHALL implement, per channel, an FSM with states OFF, WAKE, ON and IDLE; "act" means REQ[i] | FORCE_ON.
REQ-014 SHALL move OFF -> WAKE at an edge where CH_EN[i]=1 and act=1, and clear the wake counter to 0.
REQ-015 SHALL increment the wake counter each cycle in WAKE, and move WAKE -> ON at the edge where counter==WAKE_CYC-1; act is ignored during WAKE.
REQ-016 SHALL move ON -> IDLE at an edge where act=0, loading the idle counter with IDLE_CYC-1.
REQ-017 SHALL move IDLE -> ON on any edge where act=1 (counter discarded); otherwise decrement, and move IDLE -> OFF at the edge where counter==0.
REQ-018 SHALL move any state -> OFF at an edge where CH_EN[i]=0; this takes priority over every other transition.
REQ-019 SHALL drive gate enable gen[i], registered, =1 in WAKE, ON and IDLE and =0 in OFF.
REQ-020 SHALL pass gen[i] through a level latch that is transparent while CLK is low and holds while CLK is high; GATED_CLK[i] = latch output AND CLK; no glitch or truncated high pulse is permitted.
REQ-021 SHALL drive ACK[i]=1 exactly in ON and IDLE.
REQ-022 SHALL produce wake latency as follows: WAKE entered at edge k gives the first GATED_CLK rising edge at edge k+1 and ACK high after edge k+WAKE_CYC.
REQ-023 SHALL produce re-gate latency as follows: IDLE entered at edge j with no further act gives the last GATED_CLK rising edge at edge j+IDLE_CYC; ACK and gen fall after that edge.
REQ-024 SHALL operate channels fully independently; simultaneous events on different channels do not interact.
REQ-025 SHALL drive ALL_GATED=1 in a cycle iff all channel states are OFF after that edge.

Reset
REQ-026 SHALL, while RST=1, asynchronously force all FSMs to OFF, counters to 0, gen, latches, GATED_CLK and ACK to 0, and ALL_GATED to 1.
REQ-027 SHALL resume FSM operation at the first CLK rising edge after RST deasserts; an RST mid-WAKE or mid-IDLE abandons that sequence.

Verification
REQ-028 SHALL be verified with defaults: REQ[0] 0->1 sampled at edge 10 with CH_EN=4'hF -> first GATED_CLK[0] pulse at edge 11, ACK[0]=1 after edge 12, ALL_GATED=0 after edge 10.
REQ-029 SHALL be verified as follows: channel 1 in ON, REQ[1] dropped at edge 20 -> 16 more GATED_CLK[1] pulses (last at edge 36), ACK[1]=0 and GATED_CLK[1] stuck low from edge 36.
REQ-030 SHALL be verified as follows: REQ[2] dropped at edge 40 and re-raised at edge 48 -> channel returns to ON, GATED_CLK[2] continuous, ACK[2] never drops.
REQ-031 SHALL be verified as follows: FORCE_ON=1 with REQ=0 and CH_EN=4'b0101 -> channels 0 and 2 wake (ACK after 2 edges), channels 1 and 3 stay OFF with GATED_CLK low.
REQ-032 SHALL be verified as follows: CH_EN[3] cleared while channel 3 is in IDLE with counter 9 -> OFF at the next edge, no partial GATED_CLK[3] pulse.
REQ-033 SHALL be verified as follows: RST pulsed asynchronously during a channel-0 WAKE -> GATED_CLK, ACK=0 and ALL_GATED=1 immediately; a fresh REQ after release repeats the REQ-022 latency.
